riscv_mult_iter: RTL and testbench

Parametrised iterative integer multiplier for the RISC-V core execute stage, covering MUL, MULH, MULHSU and MULHU. It replaces the fixed 33x33 vendor sequential multiplier with an in-house radix-2^BPC shift-add datapath. It uses full valid/ready handshakes on both sides and supports a pipeline flush. An optional product cache returns the second half of a MULH/MUL pair in one cycle.

---
 rtl/riscv_mult_pkg.sv | 27 ++
 rtl/riscv_mult_pp.sv | 15 +
 rtl/riscv_mult_iter.sv | 236 +++++++++++++++++++++++
 tb/tb_riscv_mult_iter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mult_pkg.sv
// Shared encodings, FSM state type and signedness helper for the iterative
// RISC-V multiplier.
package riscv_mult_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Returns {sa, sb}: whether rs1 / rs2 are treated as signed.
  function automatic logic [1:0] op_signs(input logic [1:0] op);
    logic [1:0] s;
    case (op)
      OP_MULHSU: s = 2'b10;
      OP_MULHU:  s = 2'b00;
      default:   s = 2'b11;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/riscv_mult_pp.sv
// Combinational XLEN x BPC unsigned partial-product generator.
module riscv_mult_pp
  import riscv_mult_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned BPC  = 8
) (
  input  logic [XLEN-1:0]     a_i,
  input  logic [BPC-1:0]      b_i,
  output logic [XLEN+BPC-1:0] pp_o
);

  assign pp_o = {{BPC{1'b0}}, a_i} * {{XLEN{1'b0}}, b_i};

endmodule

// File: rtl/riscv_mult_iter.sv
// Iterative radix-2^BPC multiplier for MUL/MULH/MULHSU/MULHU with
// valid/ready handshakes, flush and an optional last-product cache.
//
// state | meaning
// IDLE  | ready for a request
// CALC  | retiring BPC multiplier bits per cycle
// DONE  | result held until the consumer takes it
module riscv_mult_iter
  import riscv_mult_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned BPC      = 8,
  parameter int unsigned CACHE_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int unsigned N  = XLEN / BPC;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW = 2 * XLEN;

  state_e state_q, state_d;

  logic [XLEN-1:0] mag_a_q, mag_a_d;
  logic [XLEN-1:0] mag_b_q, mag_b_d;
  logic            neg_q, neg_d;
  logic [1:0]      op_q, op_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   step_q, step_d;
  logic [XLEN-1:0] result_q, result_d;

  logic                 accept;
  logic                 last_step;
  logic                 calc_done;
  logic                 cache_hit;
  logic [PW-1:0]        cache_prod;
  logic [1:0]           in_signs;
  logic                 sign_a;
  logic                 sign_b;
  logic [XLEN+BPC-1:0]  pp;
  logic [PW-1:0]        pp_sh;
  logic [PW-1:0]        acc_sum;
  logic [PW-1:0]        prod_s;

  function automatic logic [XLEN-1:0] sel_result(input logic [1:0] op,
                                                  input logic [PW-1:0] p);
    return (op == OP_MUL) ? p[XLEN-1:0] : p[PW-1:XLEN];
  endfunction

  assign in_signs  = op_signs(op_i);
  assign sign_a    = in_signs[1] & op_a_i[XLEN-1];
  assign sign_b    = in_signs[0] & op_b_i[XLEN-1];
  assign accept    = in_valid_i && (state_q == IDLE) && !flush_i;
  assign last_step = (step_q == CW'(N - 1));
  assign calc_done = (state_q == CALC) && last_step && !flush_i;

  // mag_b_q shifts down one chunk per step, so its low BPC bits are the
  // current multiplier digit.
  riscv_mult_pp #(
    .XLEN (XLEN),
    .BPC  (BPC)
  ) u_pp (
    .a_i  (mag_a_q),
    .b_i  (mag_b_q[BPC-1:0]),
    .pp_o (pp)
  );

  assign pp_sh   = PW'(pp) << (32'(step_q) * BPC);
  assign acc_sum = acc_q + pp_sh;
  assign prod_s  = neg_q ? -acc_sum : acc_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = cache_hit ? DONE : CALC;
        end
      end
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (calc_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (flush_i || out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
    busy_o      = (state_q == CALC) || (state_q == DONE);
  end

  assign result_o = result_q;

  always_comb begin
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    neg_d    = neg_q;
    op_d     = op_q;
    acc_d    = acc_q;
    step_d   = step_q;
    result_d = result_q;
    if (accept) begin
      mag_a_d = sign_a ? -op_a_i : op_a_i;
      mag_b_d = sign_b ? -op_b_i : op_b_i;
      neg_d   = sign_a ^ sign_b;
      op_d    = op_i;
      acc_d   = '0;
      step_d  = '0;
      if (cache_hit) begin
        result_d = sel_result(op_i, cache_prod);
      end
    end else if ((state_q == CALC) && !flush_i) begin
      acc_d   = acc_sum;
      step_d  = step_q + CW'(1);
      mag_b_d = mag_b_q >> BPC;
      if (last_step) begin
        result_d = sel_result(op_q, prod_s);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      neg_q    <= 1'b0;
      op_q     <= OP_MUL;
      acc_q    <= '0;
      step_q   <= '0;
      result_q <= '0;
    end else begin
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      neg_q    <= neg_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
      result_q <= result_d;
    end
  end

  if (CACHE_EN != 0) begin : g_cache
    logic [XLEN-1:0] req_a_q, req_a_d, req_b_q, req_b_d;
    logic [1:0]      req_s_q, req_s_d;
    logic [XLEN-1:0] cache_a_q, cache_a_d, cache_b_q, cache_b_d;
    logic [1:0]      cache_s_q, cache_s_d;
    logic [PW-1:0]   cache_p_q, cache_p_d;
    logic            cache_v_q, cache_v_d;

    // The request tag is kept alongside the datapath so a completed CALC
    // can file its product under the raw operands, not the magnitudes.
    always_comb begin
      req_a_d   = req_a_q;
      req_b_d   = req_b_q;
      req_s_d   = req_s_q;
      cache_a_d = cache_a_q;
      cache_b_d = cache_b_q;
      cache_s_d = cache_s_q;
      cache_p_d = cache_p_q;
      cache_v_d = cache_v_q;
      if (accept) begin
        req_a_d = op_a_i;
        req_b_d = op_b_i;
        req_s_d = in_signs;
      end
      if (calc_done) begin
        cache_a_d = req_a_q;
        cache_b_d = req_b_q;
        cache_s_d = req_s_q;
        cache_p_d = prod_s;
        cache_v_d = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        req_a_q   <= '0;
        req_b_q   <= '0;
        req_s_q   <= '0;
        cache_a_q <= '0;
        cache_b_q <= '0;
        cache_s_q <= '0;
        cache_p_q <= '0;
        cache_v_q <= 1'b0;
      end else begin
        req_a_q   <= req_a_d;
        req_b_q   <= req_b_d;
        req_s_q   <= req_s_d;
        cache_a_q <= cache_a_d;
        cache_b_q <= cache_b_d;
        cache_s_q <= cache_s_d;
        cache_p_q <= cache_p_d;
        cache_v_q <= cache_v_d;
      end
    end

    // The low product word does not depend on signedness, so MUL hits on
    // operands alone.
    assign cache_hit = cache_v_q && (op_a_i == cache_a_q) && (op_b_i == cache_b_q) &&
                       ((op_i == OP_MUL) || (in_signs == cache_s_q));
    assign cache_prod = cache_p_q;
  end else begin : g_no_cache
    assign cache_hit  = 1'b0;
    assign cache_prod = '0;
  end

endmodule

// File: tb/tb_riscv_mult_iter.sv
// Self-checking bench: a cached BPC=8 instance and an uncached BPC=4 instance,
// directed scenarios plus a randomised scoreboard run on each.
module tb_riscv_mult_iter;

  localparam int XLEN = 32;
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush     [2];
  logic            in_valid  [2];
  logic            in_ready  [2];
  logic [1:0]      op        [2];
  logic [XLEN-1:0] op_a      [2];
  logic [XLEN-1:0] op_b      [2];
  logic            out_valid [2];
  logic            out_ready [2];
  logic [XLEN-1:0] result    [2];
  logic            busy      [2];

  int n_tests = 0;
  int n_fail  = 0;
  logic [XLEN-1:0] sb_q [$];

  always #5 clk = ~clk;

  riscv_mult_iter #(.XLEN(XLEN), .BPC(8), .CACHE_EN(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush[0]),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .op_i(op[0]),
    .op_a_i(op_a[0]), .op_b_i(op_b[0]), .out_valid_o(out_valid[0]),
    .out_ready_i(out_ready[0]), .result_o(result[0]), .busy_o(busy[0])
  );

  riscv_mult_iter #(.XLEN(XLEN), .BPC(4), .CACHE_EN(0)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush[1]),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .op_i(op[1]),
    .op_a_i(op_a[1]), .op_b_i(op_b[1]), .out_valid_o(out_valid[1]),
    .out_ready_i(out_ready[1]), .result_o(result[1]), .busy_o(busy[1])
  );

  // Reference: sign/zero extend to 2*XLEN and take the wrapped product.
  function automatic logic [XLEN-1:0] ref_mul(input logic [1:0] o,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] ae, be, p;
    ae = {{XLEN{(o != OP_MULHU) & a[XLEN-1]}}, a};
    be = {{XLEN{((o == OP_MUL) || (o == OP_MULH)) & b[XLEN-1]}}, b};
    p  = ae * be;
    return (o == OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  // Miss latency: BPC=8 -> 5 cycles, BPC=4 -> 9 cycles.
  function automatic int lat(input int d);
    return (d == 0) ? 5 : 9;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int d, input logic [1:0] o, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp_res,
                        input int exp_lat, input string name);
    int cyc;
    logic [XLEN-1:0] want;
    n_tests++;
    if (in_ready[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_before_issue: got %b want 1", name, in_ready[d]);
    end
    op[d] = o; op_a[d] = a; op_b[d] = b; in_valid[d] = 1'b1; out_ready[d] = 1'b0;
    sb_q.push_back(exp_res);
    tick();
    in_valid[d] = 1'b0;
    op[d] = 2'($urandom_range(3, 0));
    op_a[d] = $urandom; op_b[d] = $urandom;
    cyc = 1;
    while (out_valid[d] !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    n_tests++;
    if (cyc != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
    end
    want = sb_q.pop_front();
    n_tests++;
    if (result[d] !== want) begin
      n_fail++;
      $display("FAIL %s result: got %h want %h", name, result[d], want);
    end
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
    n_tests++;
    if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s handshake: got valid=%b ready=%b want valid=0 ready=1",
               name, out_valid[d], in_ready[d]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      flush[d] = 1'b0; in_valid[d] = 1'b0; op[d] = OP_MUL;
      op_a[d] = '0; op_b[d] = '0; out_ready[d] = 1'b0;
    end
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_flags dut%0d: got ready=%b valid=%b busy=%b want 1/0/0",
                 d, in_ready[d], out_valid[d], busy[d]);
      end
      n_tests++;
      if (result[d] !== '0) begin
        n_fail++;
        $display("FAIL reset_result dut%0d: got %h want 0", d, result[d]);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_unsigned_max(input int d);
    run_op(d, OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, lat(d), "umax_mul");
    run_op(d, OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, lat(d), "umax_mulhu");
  endtask

  task automatic test_signed(input int d);
    run_op(d, OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, lat(d), "mulh_m1");
    run_op(d, OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat(d), "mulhsu_m1");
    run_op(d, OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, lat(d), "mulh_min");
  endtask

  task automatic test_cache();
    run_op(0, OP_MUL,   32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1, "hit_mul");
    run_op(0, OP_MUL,   32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1, "hit_mul_again");
    run_op(0, OP_MULH,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1, "hit_mulh");
    run_op(0, OP_MULHU, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 5, "miss_mulhu");
    run_op(0, OP_MULH,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 5, "miss_mulh_after_u");
    run_op(1, OP_MUL,   32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 9, "nocache_mul");
  endtask

  task automatic test_backpressure(input int d);
    logic [XLEN-1:0] want;
    int cyc;
    op[d] = OP_MULHSU; op_a[d] = 32'h1234_5678; op_b[d] = 32'hFEDC_BA98;
    in_valid[d] = 1'b1; out_ready[d] = 1'b0;
    sb_q.push_back(ref_mul(OP_MULHSU, 32'h1234_5678, 32'hFEDC_BA98));
    tick();
    in_valid[d] = 1'b0;
    cyc = 1;
    while (out_valid[d] !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    want = sb_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (out_valid[d] !== 1'b1 || in_ready[d] !== 1'b0 || result[d] !== want) begin
        n_fail++;
        $display("FAIL bp_hold dut%0d cyc%0d: got valid=%b ready=%b res=%h want 1/0/%h",
                 d, i, out_valid[d], in_ready[d], result[d], want);
      end
      tick();
    end
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
    n_tests++;
    if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1 || busy[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release dut%0d: got valid=%b ready=%b busy=%b want 0/1/0",
               d, out_valid[d], in_ready[d], busy[d]);
    end
  endtask

  task automatic test_flush(input int d, input int stp, input logic [1:0] o,
                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input string name);
    logic [XLEN-1:0] e;
    int seen;
    e = ref_mul(o, a, b);
    op[d] = o; op_a[d] = a; op_b[d] = b; in_valid[d] = 1'b1;
    sb_q.push_back(e);
    tick();
    in_valid[d] = 1'b0;
    repeat (stp) tick();
    n_tests++;
    if (busy[d] !== 1'b1 || out_valid[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s in_calc: got busy=%b valid=%b want 1/0", name, busy[d], out_valid[d]);
    end
    flush[d] = 1'b1;
    tick();
    flush[d] = 1'b0;
    void'(sb_q.pop_front());
    n_tests++;
    if (busy[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s to_idle: got busy=%b ready=%b want 0/1", name, busy[d], in_ready[d]);
    end
    seen = 0;
    repeat (lat(d) + 2) begin
      if (out_valid[d] === 1'b1) seen++;
      tick();
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL %s no_valid: got %0d valid cycles want 0", name, seen);
    end
    run_op(d, o, a, b, e, lat(d), name);
  endtask

  task automatic test_flush_done_idle(input int d);
    int cyc;
    op[d] = OP_MUL; op_a[d] = 32'hDEAD_BEEF; op_b[d] = 32'h0000_0003; in_valid[d] = 1'b1;
    sb_q.push_back(ref_mul(OP_MUL, 32'hDEAD_BEEF, 32'h0000_0003));
    tick();
    in_valid[d] = 1'b0;
    cyc = 1;
    while (out_valid[d] !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    flush[d] = 1'b1; out_ready[d] = 1'b1;
    tick();
    flush[d] = 1'b0; out_ready[d] = 1'b0;
    void'(sb_q.pop_front());
    n_tests++;
    if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_done dut%0d: got valid=%b ready=%b want 0/1", d, out_valid[d], in_ready[d]);
    end
    in_valid[d] = 1'b1; flush[d] = 1'b1; op_a[d] = 32'h0000_0005; op_b[d] = 32'h0000_0007;
    tick();
    in_valid[d] = 1'b0; flush[d] = 1'b0;
    n_tests++;
    if (busy[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_idle dut%0d: got busy=%b ready=%b want 0/1", d, busy[d], in_ready[d]);
    end
  endtask

  task automatic test_reset_clears_cache();
    run_op(0, OP_MULH, 32'hFFFF_FFF9, 32'h0000_0009, 32'hFFFF_FFFF, 5, "rc_fill");
    run_op(0, OP_MULH, 32'hFFFF_FFF9, 32'h0000_0009, 32'hFFFF_FFFF, 1, "rc_hit");
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    run_op(0, OP_MULH, 32'hFFFF_FFF9, 32'h0000_0009, 32'hFFFF_FFFF, 5, "rc_miss_after_reset");
  endtask

  task automatic test_random(input int d, input int nops);
    logic [XLEN-1:0] pool [4];
    logic [XLEN-1:0] last_a, last_b, want, prev_res;
    logic prev_hold, acc, xfer, exp_busy;
    int done_ops, cyc;
    pool[0] = 32'h8000_0000; pool[1] = 32'hFFFF_FFFF;
    pool[2] = 32'h0000_0001; pool[3] = 32'h7FFF_FFFF;
    last_a = '0; last_b = '0; prev_hold = 1'b0; prev_res = '0;
    done_ops = 0; cyc = 0;
    while ((done_ops < nops || sb_q.size() != 0) && cyc < 30000) begin
      exp_busy = (sb_q.size() != 0);
      n_tests++;
      if (busy[d] !== exp_busy) begin
        n_fail++;
        $display("FAIL rnd_busy dut%0d cyc%0d: got %b want %b", d, cyc, busy[d], exp_busy);
      end
      if (prev_hold) begin
        n_tests++;
        if (out_valid[d] !== 1'b1 || result[d] !== prev_res) begin
          n_fail++;
          $display("FAIL rnd_stable dut%0d cyc%0d: got valid=%b res=%h want 1/%h",
                   d, cyc, out_valid[d], result[d], prev_res);
        end
      end
      if (done_ops < nops) begin
        in_valid[d]  = ($urandom_range(3, 0) != 0);
        op[d]        = 2'($urandom_range(3, 0));
        case ($urandom_range(3, 0))
          0:       begin op_a[d] = last_a; op_b[d] = last_b; end
          1:       begin op_a[d] = pool[$urandom_range(3, 0)]; op_b[d] = pool[$urandom_range(3, 0)]; end
          default: begin op_a[d] = $urandom; op_b[d] = $urandom; end
        endcase
        out_ready[d] = ($urandom_range(2, 0) != 0);
        flush[d]     = ($urandom_range(31, 0) == 0);
      end else begin
        in_valid[d] = 1'b0; flush[d] = 1'b0; out_ready[d] = 1'b1;
      end
      acc  = in_valid[d] && (in_ready[d] === 1'b1) && !flush[d];
      xfer = (out_valid[d] === 1'b1) && out_ready[d] && !flush[d];
      if (acc) begin
        sb_q.push_back(ref_mul(op[d], op_a[d], op_b[d]));
        last_a = op_a[d]; last_b = op_b[d];
      end
      if (xfer) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_spurious dut%0d cyc%0d: got result %h want none", d, cyc, result[d]);
        end else begin
          want = sb_q.pop_front();
          if (result[d] !== want) begin
            n_fail++;
            $display("FAIL rnd_result dut%0d cyc%0d: got %h want %h", d, cyc, result[d], want);
          end
        end
        done_ops++;
      end
      if (flush[d] && busy[d] === 1'b1 && sb_q.size() != 0) begin
        void'(sb_q.pop_front());
        done_ops++;
      end
      prev_hold = (out_valid[d] === 1'b1) && !out_ready[d] && !flush[d];
      prev_res  = result[d];
      tick();
      cyc++;
    end
    in_valid[d] = 1'b0; flush[d] = 1'b0; out_ready[d] = 1'b0;
    n_tests++;
    if (done_ops < nops || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL rnd_progress dut%0d: got %0d ops pending=%0d want %0d ops pending=0",
               d, done_ops, sb_q.size(), nops);
      sb_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got time limit want completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    for (int d = 0; d < 2; d++) test_unsigned_max(d);
    for (int d = 0; d < 2; d++) test_signed(d);
    test_cache();
    for (int d = 0; d < 2; d++) test_backpressure(d);
    for (int d = 0; d < 2; d++) begin
      test_flush(d, 2, OP_MULHU, 32'h0BAD_F00D, 32'h00C0_FFEE, "flush_step2");
      test_flush(d, lat(d) - 2, OP_MULH, 32'h1357_9BDF, 32'hE468_ACE0, "flush_last_step");
    end
    for (int d = 0; d < 2; d++) test_flush_done_idle(d);
    test_reset_clears_cache();
    test_random(0, 1500);
    test_random(1, 1200);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
